// File: rtl/aes_inv_cipher_iter_if.sv
// rtl/aes_inv_cipher_iter_if.sv - request/response bundle for the iterative AES-128 inverse cipher
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_out;
    logic         busy;

    modport master (
        output in_valid, cipher_in, key, out_ready,
        input  in_ready, out_valid, plain_out, busy
    );

    modport slave (
        input  in_valid, cipher_in, key, out_ready,
        output in_ready, out_valid, plain_out, busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 inverse cipher with on-the-fly key un-expansion
module aes_inv_cipher_iter #(
    parameter int REUSE_KEY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_inv_cipher_iter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, KEXP, ADD, ROUND, DONE} state_t;

    state_t       state, next;
    logic [3:0]   cnt;
    logic [127:0] rk, st, key_reg;
    logic [127:0] cache_key, cache_k10;
    logic         cache_valid;
    logic         hit;
    logic [127:0] k_fwd, k_r, t, mixed;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); 0 maps to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Recovers the previous round key from the current one
    function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    assign hit   = (REUSE_KEY != 0) && cache_valid && (bus.key == cache_key);
    assign k_fwd = fwd_expand(rk, rcon(cnt));
    assign k_r   = inv_expand(rk, rcon(cnt + 4'd1));
    assign t     = inv_sub_shift(st) ^ k_r;
    assign mixed = {inv_mix_col(t[127:96]), inv_mix_col(t[95:64]),
                    inv_mix_col(t[63:32]), inv_mix_col(t[31:0])};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next          = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.plain_out = '0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) next = hit ? ADD : KEXP;
            end
            KEXP:  if (cnt == 4'd10) next = ADD;
            ADD:   next = ROUND;
            ROUND: if (cnt == 4'd0) next = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.plain_out = st;
                if (bus.out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            rk          <= '0;
            st          <= '0;
            key_reg     <= '0;
            cache_key   <= '0;
            cache_k10   <= '0;
            cache_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    st      <= bus.cipher_in;
                    key_reg <= bus.key;
                    if (hit) begin
                        rk <= cache_k10;
                    end else begin
                        rk  <= bus.key;
                        cnt <= 4'd1;
                    end
                end
                KEXP: begin
                    rk  <= k_fwd;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd10 && REUSE_KEY != 0) begin
                        cache_valid <= 1'b1;
                        cache_key   <= key_reg;
                        cache_k10   <= k_fwd;
                    end
                end
                ADD: begin
                    st  <= st ^ rk;
                    cnt <= 4'd9;
                end
                ROUND: begin
                    st  <= (cnt != 4'd0) ? mixed : t;
                    rk  <= k_r;
                    cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - scoreboard bench for the iterative AES-128 inverse cipher
module tb_aes_inv_cipher_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_cipher_iter_if bus();
    aes_inv_cipher_iter #(.REUSE_KEY(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [127:0] data;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic         prev_valid = 1'b0;
    logic [7:0]   sb[256];
    logic [127:0] last_key = '0;
    bit           model_cache = 1'b0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: latency on the out_valid rising edge, data on handshake
    always @(negedge clk) begin
        if (bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) fail_now("spurious_valid: out_valid with empty scoreboard");
            else check("latency", 128'(cyc - exp_q[0].acc), 128'(exp_q[0].lat));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) fail_now("spurious_out: handshake with empty scoreboard");
            else begin
                check("plain_out", bus.plain_out, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
        prev_valid = bus.out_valid;
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_sbox();
        logic [7:0] ex[256];
        int         lg[256];
        logic [7:0] x, v;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ xt(x);
        end
        sb[0] = 8'h63;
        for (int a = 1; a < 256; a++) begin
            v = ex[(255 - lg[a]) % 255];
            sb[a] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w[44];
        logic [7:0]   s[16];
        logic [7:0]   n[16];
        logic [31:0]  tw;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i - 1];
            if (i % 4 == 0) begin
                tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tw;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127 - 8 * j -: 8] ^ w[j / 4][31 - 8 * (j % 4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    n[4 * c + r] = sb[s[4 * ((c + r) % 4) + r]];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = n[4 * c]; a1 = n[4 * c + 1]; a2 = n[4 * c + 2]; a3 = n[4 * c + 3];
                    n[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    n[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    n[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    n[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = n[j] ^ w[4 * rd + j / 4][31 - 8 * (j % 4) -: 8];
        end
        o = '0;
        for (int j = 0; j < 16; j++) o[127 - 8 * j -: 8] = s[j];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt, input bit record);
        int   n;
        exp_t e;
        n = 0;
        step();
        bus.in_valid  = 1'b1;
        bus.key       = k;
        bus.cipher_in = ct;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_now("accept_timeout: in_ready never rose");
        else if (record) begin
            e.data = pt;
            e.acc  = cyc + 1;
            e.lat  = (model_cache && k == last_key) ? 11 : 21;
            exp_q.push_back(e);
            last_key    = k;
            model_cache = 1'b1;
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.busy) fail_now("drain_timeout: results still outstanding");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, pt;
        int           n;
        build_sbox();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.key       = '0;
        bus.cipher_in = '0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_plain_out", bus.plain_out, 128'h0);
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));

        // FIPS vectors, cache hit, then key change
        issue(K1, C1, P1, 1'b1);
        issue(K2, C2, P2, 1'b1);
        issue(K2, C2, P2, 1'b1);
        issue(K1, C1, P1, 1'b1);
        drain();
        check("model_self_check", enc(P2, K2), C2);

        // Backpressure in DONE
        step();
        bus.out_ready = 1'b0;
        issue(K1, C1, P1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_now("bp_timeout: out_valid never rose");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check("bp_plain_out", bus.plain_out, P1);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check("bp_busy", 128'(bus.busy), 128'(1));
        end
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
        check("bp_release_out_valid", 128'(bus.out_valid), 128'(0));
        step();
        bus.out_ready = 1'b1;
        check("bp_scoreboard_empty", 128'(exp_q.size()), 128'(0));

        // Reset in the middle of ROUND (cache hit, so r=4 six edges after accept)
        issue(K1, C1, P1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_cache = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        issue(K1, C1, P1, 1'b1);
        drain();

        // Loopback through the bench encryptor; every fourth block reuses the key
        k = '0;
        for (int i = 0; i < 200; i++) begin
            if (i % 4 != 3) k = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            issue(k, enc(pt, k), pt, 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
